// File: rtl/rs_alu_scheduler_pkg.sv
// Shared definitions for the ALU reservation station.
//   - op codes, ROB tag width, op code width
//   - default RS depth
//   - rs_entry_t: payload of one waiting instruction (valid bit kept separately)
//   - cdb_hit(): tag match of a pending operand against one broadcast bus
package rs_alu_scheduler_pkg;

  localparam int ROB_SIZE_LOG    = 4;
  localparam int OP_SIZE_LOG     = 5;
  localparam int RS_SIZE_DEF     = 16;
  localparam int RS_SIZE_LOG_DEF = 4;

  localparam logic [OP_SIZE_LOG-1:0] OP_NOP = 5'd0;
  localparam logic [OP_SIZE_LOG-1:0] OP_ADD = 5'd1;
  localparam logic [OP_SIZE_LOG-1:0] OP_SUB = 5'd2;
  localparam logic [OP_SIZE_LOG-1:0] OP_AND = 5'd3;
  localparam logic [OP_SIZE_LOG-1:0] OP_OR  = 5'd4;
  localparam logic [OP_SIZE_LOG-1:0] OP_XOR = 5'd5;
  localparam logic [OP_SIZE_LOG-1:0] OP_BEQ = 5'd6;
  localparam logic [OP_SIZE_LOG-1:0] OP_BNE = 5'd7;

  typedef struct packed {
    logic [OP_SIZE_LOG-1:0]  op;
    logic [31:0]             vj;
    logic [31:0]             vk;
    logic                    qj_busy;
    logic                    qk_busy;
    logic [ROB_SIZE_LOG-1:0] qj;
    logic [ROB_SIZE_LOG-1:0] qk;
    logic [31:0]             imm;
    logic [31:0]             pc;
    logic [ROB_SIZE_LOG-1:0] reorder;
  } rs_entry_t;

  function automatic logic cdb_hit(input logic                    cdb_valid,
                                   input logic [ROB_SIZE_LOG-1:0] cdb_tag,
                                   input logic [ROB_SIZE_LOG-1:0] q);
    return cdb_valid && (cdb_tag == q);
  endfunction

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index set-bit encoder.
//   req   : request vector, bit 0 has highest priority
//   idx   : index of the lowest set bit (0 when none set)
//   found : at least one bit of req is set
module rs_prio_enc #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan downward so the last hit, which is the lowest index, wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_alu_scheduler.sv
// Reservation station and issue scheduler in front of the combinational ALU.
// Holds up to RS_SIZE decoded ops, wakes operands from the ALU and LSB CDBs,
// and issues the lowest-index ready entry each cycle on registered outputs.
//   clk, rst (async, active-low), rdy (0 freezes everything), jump_rst (flush)
//   disp_*      : dispatch request and decoded op fields
//   full        : no free entry (from registered valid bits only)
//   alu_cdb_*   : ALU result broadcast
//   lsb_cdb_*   : load result broadcast
//   RS_valid, op, Vj, Vk, imm, curPC, RS_reorder : issue to the ALU
module rs_alu_scheduler
  import rs_alu_scheduler_pkg::*;
#(
  parameter int RS_SIZE     = RS_SIZE_DEF,
  parameter int RS_SIZE_LOG = RS_SIZE_LOG_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    jump_rst,
  input  logic                    disp_valid,
  input  logic [OP_SIZE_LOG-1:0]  disp_op,
  input  logic [31:0]             disp_Vj,
  input  logic [31:0]             disp_Vk,
  input  logic                    disp_Qj_busy,
  input  logic                    disp_Qk_busy,
  input  logic [ROB_SIZE_LOG-1:0] disp_Qj,
  input  logic [ROB_SIZE_LOG-1:0] disp_Qk,
  input  logic [31:0]             disp_imm,
  input  logic [31:0]             disp_pc,
  input  logic [ROB_SIZE_LOG-1:0] disp_reorder,
  output logic                    full,
  input  logic                    alu_cdb_valid,
  input  logic [ROB_SIZE_LOG-1:0] alu_cdb_reorder,
  input  logic [31:0]             alu_cdb_val,
  input  logic                    lsb_cdb_valid,
  input  logic [ROB_SIZE_LOG-1:0] lsb_cdb_reorder,
  input  logic [31:0]             lsb_cdb_val,
  output logic                    RS_valid,
  output logic [OP_SIZE_LOG-1:0]  op,
  output logic [31:0]             Vj,
  output logic [31:0]             Vk,
  output logic [31:0]             imm,
  output logic [31:0]             curPC,
  output logic [ROB_SIZE_LOG-1:0] RS_reorder
);

  logic [RS_SIZE-1:0]     ent_valid;
  logic [RS_SIZE-1:0]     valid_nxt;
  rs_entry_t              ent     [RS_SIZE];
  rs_entry_t              ent_nxt [RS_SIZE];
  rs_entry_t              disp_entry;

  logic [RS_SIZE-1:0]     ready_vec;
  logic [RS_SIZE-1:0]     free_vec;
  logic [RS_SIZE_LOG-1:0] ready_idx;
  logic [RS_SIZE_LOG-1:0] free_idx;
  logic                   ready_found;
  logic                   free_found;
  logic                   disp_fire;

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = ent_valid[i] && !ent[i].qj_busy && !ent[i].qk_busy;
    end
  end

  assign free_vec = ~ent_valid;

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(RS_SIZE_LOG)) u_free_enc (
    .req   (free_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(RS_SIZE_LOG)) u_ready_enc (
    .req   (ready_vec),
    .idx   (ready_idx),
    .found (ready_found)
  );

  assign full      = !free_found;
  assign disp_fire = disp_valid && free_found;

  // Incoming op, with operands already produced on a CDB this cycle captured
  // directly so they do not wait on a broadcast that has already gone by.
  always_comb begin
    disp_entry.op      = disp_op;
    disp_entry.vj      = disp_Vj;
    disp_entry.vk      = disp_Vk;
    disp_entry.qj_busy = disp_Qj_busy;
    disp_entry.qk_busy = disp_Qk_busy;
    disp_entry.qj      = disp_Qj;
    disp_entry.qk      = disp_Qk;
    disp_entry.imm     = disp_imm;
    disp_entry.pc      = disp_pc;
    disp_entry.reorder = disp_reorder;
    if (disp_Qj_busy) begin
      if (cdb_hit(alu_cdb_valid, alu_cdb_reorder, disp_Qj)) begin
        disp_entry.vj      = alu_cdb_val;
        disp_entry.qj_busy = 1'b0;
      end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_reorder, disp_Qj)) begin
        disp_entry.vj      = lsb_cdb_val;
        disp_entry.qj_busy = 1'b0;
      end
    end
    if (disp_Qk_busy) begin
      if (cdb_hit(alu_cdb_valid, alu_cdb_reorder, disp_Qk)) begin
        disp_entry.vk      = alu_cdb_val;
        disp_entry.qk_busy = 1'b0;
      end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_reorder, disp_Qk)) begin
        disp_entry.vk      = lsb_cdb_val;
        disp_entry.qk_busy = 1'b0;
      end
    end
  end

  // Wakeup of waiting entries plus the dispatch write. The dispatch slot is
  // free by construction, so it never collides with a wakeup or the issue.
  always_comb begin
    ent_nxt = ent;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ent_valid[i] && ent[i].qj_busy) begin
        if (cdb_hit(alu_cdb_valid, alu_cdb_reorder, ent[i].qj)) begin
          ent_nxt[i].vj      = alu_cdb_val;
          ent_nxt[i].qj_busy = 1'b0;
        end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_reorder, ent[i].qj)) begin
          ent_nxt[i].vj      = lsb_cdb_val;
          ent_nxt[i].qj_busy = 1'b0;
        end
      end
      if (ent_valid[i] && ent[i].qk_busy) begin
        if (cdb_hit(alu_cdb_valid, alu_cdb_reorder, ent[i].qk)) begin
          ent_nxt[i].vk      = alu_cdb_val;
          ent_nxt[i].qk_busy = 1'b0;
        end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_reorder, ent[i].qk)) begin
          ent_nxt[i].vk      = lsb_cdb_val;
          ent_nxt[i].qk_busy = 1'b0;
        end
      end
    end
    if (disp_fire) begin
      ent_nxt[free_idx] = disp_entry;
    end
  end

  always_comb begin
    valid_nxt = ent_valid;
    if (ready_found) begin
      valid_nxt[ready_idx] = 1'b0;
    end
    if (disp_fire) begin
      valid_nxt[free_idx] = 1'b1;
    end
  end

  // Entry payload carries no reset; an entry is only meaningful while its
  // valid bit is set, and the valid bits are reset below.
  always_ff @(posedge clk) begin
    if (rdy && !jump_rst) begin
      ent <= ent_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_valid  <= '0;
      RS_valid   <= 1'b0;
      op         <= OP_NOP;
      Vj         <= '0;
      Vk         <= '0;
      imm        <= '0;
      curPC      <= '0;
      RS_reorder <= '0;
    end else if (rdy) begin
      if (jump_rst) begin
        ent_valid <= '0;
        RS_valid  <= 1'b0;
        op        <= OP_NOP;
      end else begin
        ent_valid <= valid_nxt;
        if (ready_found) begin
          RS_valid   <= 1'b1;
          op         <= ent[ready_idx].op;
          Vj         <= ent[ready_idx].vj;
          Vk         <= ent[ready_idx].vk;
          imm        <= ent[ready_idx].imm;
          curPC      <= ent[ready_idx].pc;
          RS_reorder <= ent[ready_idx].reorder;
        end else begin
          RS_valid <= 1'b0;
          op       <= OP_NOP;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_alu_scheduler.sv
// Directed bench for rs_alu_scheduler. Expected issues are queued when the
// stimulus that makes them issuable is driven; a negedge monitor pops and
// compares every issue. Cycle-exact checks run inline in the main sequence.
module tb_rs_alu_scheduler;
  import rs_alu_scheduler_pkg::*;

  localparam int OPW = OP_SIZE_LOG;
  localparam int RW  = ROB_SIZE_LOG;

  logic            clk;
  logic            rst;
  logic            rdy;
  logic            jump_rst;
  logic            disp_valid;
  logic [OPW-1:0]  disp_op;
  logic [31:0]     disp_Vj, disp_Vk;
  logic            disp_Qj_busy, disp_Qk_busy;
  logic [RW-1:0]   disp_Qj, disp_Qk;
  logic [31:0]     disp_imm, disp_pc;
  logic [RW-1:0]   disp_reorder;
  logic            full;
  logic            alu_cdb_valid;
  logic [RW-1:0]   alu_cdb_reorder;
  logic [31:0]     alu_cdb_val;
  logic            lsb_cdb_valid;
  logic [RW-1:0]   lsb_cdb_reorder;
  logic [31:0]     lsb_cdb_val;
  logic            RS_valid;
  logic [OPW-1:0]  op;
  logic [31:0]     Vj, Vk, imm, curPC;
  logic [RW-1:0]   RS_reorder;

  rs_alu_scheduler dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_rst(jump_rst),
    .disp_valid(disp_valid), .disp_op(disp_op),
    .disp_Vj(disp_Vj), .disp_Vk(disp_Vk),
    .disp_Qj_busy(disp_Qj_busy), .disp_Qk_busy(disp_Qk_busy),
    .disp_Qj(disp_Qj), .disp_Qk(disp_Qk),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_reorder(disp_reorder),
    .full(full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_reorder(alu_cdb_reorder), .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_reorder(lsb_cdb_reorder), .lsb_cdb_val(lsb_cdb_val),
    .RS_valid(RS_valid), .op(op), .Vj(Vj), .Vk(Vk), .imm(imm), .curPC(curPC),
    .RS_reorder(RS_reorder)
  );

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [31:0]    vj;
    logic [31:0]    vk;
    logic [31:0]    imm;
    logic [31:0]    pc;
    logic [RW-1:0]  rob;
  } iss_t;

  iss_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic last_rdy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) last_rdy <= rdy;

  function automatic iss_t mk(input logic [OPW-1:0] o, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] i, input logic [31:0] p, input logic [RW-1:0] r);
    iss_t e;
    e.op = o; e.vj = a; e.vk = b; e.imm = i; e.pc = p; e.rob = r;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every fresh issue (RS_valid after an rdy=1 edge) must match
  // the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && RS_valid && last_rdy) begin
      iss_t got;
      iss_t want;
      got = {op, Vj, Vk, imm, curPC, RS_reorder};
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL issue_unexpected observed_rob=0x%0h expected=none", RS_reorder);
      end
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        n_checks++;
        assert (got === want) else begin
          n_fail++;
          $error("FAIL issue_payload observed=0x%0h expected=0x%0h", got, want);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid    = 1'b0;
    alu_cdb_valid = 1'b0;
    lsb_cdb_valid = 1'b0;
    jump_rst      = 1'b0;
  endtask

  task automatic set_disp(input logic [OPW-1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic qjb, input logic [RW-1:0] qj,
                          input logic qkb, input logic [RW-1:0] qk,
                          input logic [31:0] i, input logic [31:0] p, input logic [RW-1:0] r);
    disp_valid   = 1'b1;
    disp_op      = o;
    disp_Vj      = a;
    disp_Vk      = b;
    disp_Qj_busy = qjb;
    disp_Qj      = qj;
    disp_Qk_busy = qkb;
    disp_Qk      = qk;
    disp_imm     = i;
    disp_pc      = p;
    disp_reorder = r;
  endtask

  task automatic alu_bc(input logic [RW-1:0] t, input logic [31:0] v);
    alu_cdb_valid = 1'b1; alu_cdb_reorder = t; alu_cdb_val = v;
  endtask

  task automatic lsb_bc(input logic [RW-1:0] t, input logic [31:0] v);
    lsb_cdb_valid = 1'b1; lsb_cdb_reorder = t; lsb_cdb_val = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; jump_rst = 1'b0;
    disp_valid = 1'b0; disp_op = OP_NOP; disp_Vj = '0; disp_Vk = '0;
    disp_Qj_busy = 1'b0; disp_Qk_busy = 1'b0; disp_Qj = '0; disp_Qk = '0;
    disp_imm = '0; disp_pc = '0; disp_reorder = '0;
    alu_cdb_valid = 1'b0; alu_cdb_reorder = '0; alu_cdb_val = '0;
    lsb_cdb_valid = 1'b0; lsb_cdb_reorder = '0; lsb_cdb_val = '0;

    // reset
    #2 rst = 1'b0;
    #1;
    chk("rst_rs_valid", 32'(RS_valid), 32'd0);
    chk("rst_op", 32'(op), 32'(OP_NOP));
    chk("rst_vj", Vj, 32'd0);
    chk("rst_reorder", 32'(RS_reorder), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    cyc(); cyc();
    @(negedge clk);
    rst = 1'b1;
    cyc();

    // no-dependency ADD issues one cycle after dispatch
    set_disp(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 32'h100, 4'd3);
    exp_q.push_back(mk(OP_ADD, 32'd5, 32'd7, 32'h0, 32'h100, 4'd3));
    cyc(); idle();
    chk("add_not_same_cycle", 32'(RS_valid), 32'd0);
    cyc();
    chk("add_rs_valid", 32'(RS_valid), 32'd1);
    chk("add_op", 32'(op), 32'(OP_ADD));
    chk("add_reorder", 32'(RS_reorder), 32'd3);
    chk("add_alu_result", Vj + Vk, 32'd12);
    cyc();
    chk("add_single_pulse", 32'(RS_valid), 32'd0);

    // SUB waiting on tag 2, woken by ALU CDB
    set_disp(OP_SUB, 32'd0, 32'd10, 1'b1, 4'd2, 1'b0, 4'd0, 32'h20, 32'h104, 4'd5);
    cyc(); idle();
    cyc();
    chk("sub_blocked", 32'(RS_valid), 32'd0);
    alu_bc(4'd2, 32'd100);
    exp_q.push_back(mk(OP_SUB, 32'd100, 32'd10, 32'h20, 32'h104, 4'd5));
    cyc(); idle();
    chk("sub_not_on_wake_edge", 32'(RS_valid), 32'd0);
    cyc();
    chk("sub_issue", 32'(RS_valid), 32'd1);
    chk("sub_vj", Vj, 32'd100);
    cyc();

    // dispatch bypass from LSB CDB
    set_disp(OP_ADD, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4, 32'h0, 32'h108, 4'd6);
    lsb_bc(4'd4, 32'hDEAD);
    exp_q.push_back(mk(OP_ADD, 32'd1, 32'hDEAD, 32'h0, 32'h108, 4'd6));
    cyc(); idle();
    chk("bypass_not_same_cycle", 32'(RS_valid), 32'd0);
    cyc();
    chk("bypass_issue", 32'(RS_valid), 32'd1);
    chk("bypass_vk", Vk, 32'hDEAD);
    cyc();

    // fill all 16 entries with blocked ops (entry i waits on tag i)
    for (int i = 0; i < 16; i++) begin
      set_disp(OP_ADD, 32'd0, 32'(i), 1'b1, 4'(i), 1'b0, 4'd0, 32'(i), 32'h2000 + 32'(i * 4), 4'(i));
      cyc();
    end
    idle();
    chk("fill_full", 32'(full), 32'd1);
    // 17th dispatch, waiting on tag 9 too: must be dropped
    set_disp(OP_SUB, 32'h17, 32'h17, 1'b1, 4'd9, 1'b0, 4'd0, 32'h17, 32'h3000, 4'd15);
    cyc(); idle();
    chk("drop_still_full", 32'(full), 32'd1);
    alu_bc(4'd9, 32'h900);
    exp_q.push_back(mk(OP_ADD, 32'h900, 32'd9, 32'd9, 32'h2024, 4'd9));
    cyc(); idle();
    chk("wake9_full", 32'(full), 32'd1);
    chk("wake9_not_yet", 32'(RS_valid), 32'd0);
    cyc();
    chk("wake9_issue", 32'(RS_valid), 32'd1);
    chk("wake9_reorder", 32'(RS_reorder), 32'd9);
    chk("wake9_full_drops", 32'(full), 32'd0);
    set_disp(OP_SUB, 32'd50, 32'd8, 1'b0, 4'd0, 1'b0, 4'd0, 32'h5, 32'h4000, 4'd10);
    exp_q.push_back(mk(OP_SUB, 32'd50, 32'd8, 32'h5, 32'h4000, 4'd10));
    cyc(); idle();
    chk("refill_full", 32'(full), 32'd1);
    chk("refill_no_issue", 32'(RS_valid), 32'd0);
    cyc();
    chk("refill_issue", 32'(RS_valid), 32'd1);
    chk("refill_reorder", 32'(RS_reorder), 32'd10);
    chk("refill_full_drops", 32'(full), 32'd0);

    // flush the remaining 15 blocked entries
    jump_rst = 1'b1;
    cyc(); idle();
    chk("flush1_rs_valid", 32'(RS_valid), 32'd0);
    chk("flush1_full", 32'(full), 32'd0);

    // select priority: entries 1 and 5 become ready together
    for (int i = 0; i < 6; i++) begin
      set_disp(OP_OR, 32'd0, 32'h40 + 32'(i), 1'b1, 4'(i), 1'b0, 4'd0, 32'd0, 32'h5000 + 32'(i * 4), 4'(i));
      cyc();
    end
    idle();
    alu_bc(4'd1, 32'h11);
    lsb_bc(4'd5, 32'h55);
    exp_q.push_back(mk(OP_OR, 32'h11, 32'h41, 32'd0, 32'h5004, 4'd1));
    exp_q.push_back(mk(OP_OR, 32'h55, 32'h45, 32'd0, 32'h5014, 4'd5));
    cyc(); idle();
    chk("prio_not_yet", 32'(RS_valid), 32'd0);
    cyc();
    chk("prio_first_valid", 32'(RS_valid), 32'd1);
    chk("prio_first_rob", 32'(RS_reorder), 32'd1);
    cyc();
    chk("prio_second_valid", 32'(RS_valid), 32'd1);
    chk("prio_second_rob", 32'(RS_reorder), 32'd5);
    cyc();
    chk("prio_done", 32'(RS_valid), 32'd0);

    // six valid entries, entry 0 made ready, then flush with a dispatch
    set_disp(OP_XOR, 32'd0, 32'd0, 1'b1, 4'd7, 1'b0, 4'd0, 32'd0, 32'h6000, 4'd7);
    cyc();
    set_disp(OP_XOR, 32'd0, 32'd0, 1'b1, 4'd8, 1'b0, 4'd0, 32'd0, 32'h6004, 4'd8);
    cyc(); idle();
    alu_bc(4'd0, 32'h1234);
    cyc(); idle();
    jump_rst = 1'b1;
    set_disp(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h7000, 4'd11);
    cyc(); idle();
    chk("flush2_rs_valid", 32'(RS_valid), 32'd0);
    chk("flush2_op", 32'(op), 32'(OP_NOP));
    chk("flush2_full", 32'(full), 32'd0);
    alu_bc(4'd2, 32'h22);
    lsb_bc(4'd7, 32'h77);
    cyc(); idle();
    cyc();
    chk("flush2_no_issue_a", 32'(RS_valid), 32'd0);
    cyc();
    chk("flush2_no_issue_b", 32'(RS_valid), 32'd0);

    // rdy=0 freeze with a ready entry and CDB traffic
    set_disp(OP_ADD, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 32'h9, 32'h8000, 4'd12);
    exp_q.push_back(mk(OP_ADD, 32'd3, 32'd4, 32'h9, 32'h8000, 4'd12));
    cyc();
    rdy = 1'b0;
    set_disp(OP_SUB, 32'd6, 32'd6, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 32'h8004, 4'd13);
    alu_bc(4'd13, 32'hAA);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("frozen_no_issue", 32'(RS_valid), 32'd0);
      chk("frozen_full", 32'(full), 32'd0);
    end
    rdy = 1'b1;
    idle();
    cyc();
    chk("resume_issue", 32'(RS_valid), 32'd1);
    chk("resume_reorder", 32'(RS_reorder), 32'd12);
    cyc();
    chk("resume_no_extra", 32'(RS_valid), 32'd0);

    // async reset mid-stream
    set_disp(OP_SUB, 32'd9, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 32'h3, 32'h9000, 4'd14);
    exp_q.push_back(mk(OP_SUB, 32'd9, 32'd2, 32'h3, 32'h9000, 4'd14));
    cyc();
    set_disp(OP_AND, 32'd0, 32'd1, 1'b1, 4'd3, 1'b0, 4'd0, 32'h0, 32'h9004, 4'd1);
    cyc(); idle();
    chk("pre_rst_issue", 32'(RS_valid), 32'd1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_rs_valid", 32'(RS_valid), 32'd0);
    chk("async_rst_op", 32'(op), 32'(OP_NOP));
    chk("async_rst_vj", Vj, 32'd0);
    chk("async_rst_vk", Vk, 32'd0);
    chk("async_rst_imm", imm, 32'd0);
    chk("async_rst_pc", curPC, 32'd0);
    chk("async_rst_reorder", 32'(RS_reorder), 32'd0);
    chk("async_rst_full", 32'(full), 32'd0);
    rst = 1'b1;
    alu_bc(4'd3, 32'h33);
    cyc(); idle();
    cyc();
    chk("post_rst_no_issue", 32'(RS_valid), 32'd0);
    cyc();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_alu_scheduler.md
Name: rs_alu_scheduler

Overview:
- Reservation station and issue scheduler sitting in front of the combinational ALU.
- Accepts decoded arithmetic and branch ops from dispatch, and holds up to RS_SIZE waiting instructions.
- Wakes source operands by snooping the ALU and LSB CDB broadcasts.
- Issues at most one ready instruction per cycle on registered outputs, which feed the ALU's RS_* inputs directly.

Parameters:
- RS_SIZE, 16, number of entries; must be a power of two.
- RS_SIZE_LOG, 4, log2(RS_SIZE).
- ROB_SIZE_LOG, `ROB_SIZE_LOG, width of ROB reorder tags.
- OP_SIZE_LOG, `OP_SIZE_LOG, width of the op code.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low (rst==0 resets).
- rdy  in  1  global ready; 0 freezes all state.
- jump_rst  in  1  misprediction flush.
- disp_valid  in  1  dispatch request.
- disp_op  in  OP_SIZE_LOG  op code.
- disp_Vj, disp_Vk  in  32  operand values, meaningful when not busy.
- disp_Qj_busy, disp_Qk_busy  in  1  operand still pending.
- disp_Qj, disp_Qk  in  ROB_SIZE_LOG  producing ROB tag.
- disp_imm, disp_pc  in  32  immediate and instruction PC.
- disp_reorder  in  ROB_SIZE_LOG  destination ROB tag.
- full  out  1  no free entry (combinational from registered valid bits).
- alu_cdb_valid  in  1  ALU result broadcast.
- alu_cdb_reorder  in  ROB_SIZE_LOG  broadcast tag.
- alu_cdb_val  in  32  broadcast value.
- lsb_cdb_valid, lsb_cdb_reorder, lsb_cdb_val  in  1/ROB_SIZE_LOG/32  load result broadcast.
- RS_valid  out  1  issue strobe to ALU.
- op  out  OP_SIZE_LOG  issued op.
- Vj, Vk, imm, curPC  out  32  issued operands.
- RS_reorder  out  ROB_SIZE_LOG  issued ROB tag.

Behaviour:
- Reset (rst==0, async): all entry valid bits 0, RS_valid=0, op=`NOP, Vj=Vk=imm=curPC=0, RS_reorder=0; full=0.
- Entry fields: valid, op, Vj, Vk, Qj_busy, Qk_busy, Qj, Qk, imm, pc, reorder.
- rdy==0: no state change, outputs hold, CDB and dispatch inputs ignored.
- Dispatch:
  - When disp_valid && !full, write the lowest-index free entry.
  - full is evaluated from the current state. An entry freed by issue in the same cycle does not make room; dispatch while full is dropped, and upstream must hold.
- Dispatch bypass: if disp_Qx_busy and a valid CDB broadcast this cycle matches disp_Qx, store that CDB value with busy=0. ALU CDB takes priority over LSB if both match (cannot legally happen).
- Wakeup: every valid entry with Qx_busy and Qx==cdb_reorder captures cdb_val and clears Qx_busy at the clock edge. Both CDBs are checked independently each cycle.
- Ready: valid && !Qj_busy && !Qk_busy, using registered state only. Entries woken or dispatched this cycle are issuable no earlier than the next cycle. Minimum dispatch-to-RS_valid latency is 1 cycle for an entry with no dependencies.
- Select: lowest-index ready entry.
  - At the edge: copy its fields to the output registers, set RS_valid=1, clear the entry's valid bit.
  - If no entry is ready: RS_valid=0 and op=`NOP; the other outputs hold.
  - RS_valid is a one-cycle pulse per issued instruction; back-to-back issues are allowed.
- Same entry cannot issue and be rewritten in one cycle, because the free slot is chosen from the pre-edge valid bits.
- jump_rst (with rdy=1): at the edge, clear all valid bits and set RS_valid=0, op=`NOP. Same-cycle dispatch, wakeup and issue are discarded. jump_rst takes priority over all other actions.
- Reset asserted mid-operation: immediate clear regardless of clk or rdy.

Decomposition:
- config.v (shared):
  - op code defines (`NOP, `ADD, ...), `ROB_SIZE_LOG, `OP_SIZE_LOG.
  - RS_SIZE and RS_SIZE_LOG defaults.
- Sub-module rs_prio_enc: parameterized lowest-index-set-bit encoder (RS_SIZE in; index and found flag out). Instantiated twice, for the free slot and the ready slot.

Test Plan:
- Reset, then dispatch ADD Vj=5, Vk=7, no deps, reorder=3 -> next cycle RS_valid=1, op=`ADD, Vj=5, Vk=7, RS_reorder=3; the ALU returns val=12.
- Dispatch SUB with Qj_busy, Qj=2; two cycles later alu_cdb reorder=2, val=100 -> RS_valid rises exactly one cycle after the broadcast with Vj=100.
- Dispatch with Qk=4 busy in the same cycle as lsb_cdb reorder=4, val=0xDEAD -> the entry stores Vk=0xDEAD, not busy, and issues the next cycle.
- Fill all 16 entries with blocked ops -> full=1; a 17th dispatch is dropped. Wake entry 9 -> it issues and full drops. Subsequent dispatch lands in slot 9.
- Entries 1 and 5 both ready -> entry 1 issues first, entry 5 issues the following cycle.
- With 6 entries valid, assert jump_rst with a simultaneous dispatch -> next cycle RS_valid=0 and full=0. No further issue occurs even when a matching CDB arrives.
- Hold rdy=0 for 3 cycles with a ready entry and CDB traffic -> no issue and no state change; issue resumes the cycle after rdy=1.
- Pulse rst low mid-stream -> outputs and valid bits clear immediately without waiting for a clock edge.
